switch_debounce: RTL
====================

# switch_debounce

Synchronises and debounces the four board slide switches before they reach the HPS switch PIO input, so software reads clean levels instead of raw contact bounce. It sits between the `SWITCH_ARRAY_IO` pins and the PIO export in the top level, running on `CLOCK50`. It also produces per-switch edge pulses and a sticky change-event register that the PIO-side logic can poll and clear.

## Interface
- `WIDTH`, 4, number of switch channels.
- `DEBOUNCE_CYCLES`, 500000, consecutive cycles a new level must persist before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `CLOCK50` in 1: sole clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset (fixed; asserts immediately, deassertion is synchronous to the board reset release).
- `sw_raw` in WIDTH: raw switch pins, asynchronous to `CLOCK50`.
- `sw_stable` out WIDTH: debounced level, registered.
- `sw_rise` out WIDTH: one-cycle pulse when the `sw_stable` bit goes 0→1.
- `sw_fall` out WIDTH: one-cycle pulse when the `sw_stable` bit goes 1→0.
- `event_mask` out WIDTH: sticky flag per bit, set on any `sw_stable` change.
- `event_pending` out 1: OR of `event_mask`, registered.
- `event_clear` in 1: synchronous, one-cycle strobe that clears `event_mask`.

## Operation
- Per channel: 2-FF synchroniser (`s1`, `s2`), counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`, and a `stable` register.
- Each edge:
  - If `s2 == stable`: `cnt` ← 0.
  - If `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt+1`.
  - If `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `s2`, `cnt` ← 0, and the matching rise/fall pulse asserts for exactly one cycle.
- A bounce, meaning `s2` returns to `stable` before the terminal count, resets `cnt`. No output change.
- Channels are fully independent. Several bits may change on the same edge.
- Event logic:
  - `event_mask[i]` ← 1 on any edge where `stable[i]` changes.
  - `event_clear` zeroes all bits not changing on that same edge.
  - On simultaneous set and clear, the set wins.
- `event_pending` is registered from the next-state `event_mask`, so it tracks `event_mask` on the same edge.
- Reset values: `s1`, `s2`, `stable`, `cnt` = 0. All outputs = 0.
- A switch already high at reset release is treated as a normal 0→1 change: it yields `sw_rise` plus `event_mask` after the normal debounce latency.
- Reset asserted mid-count discards the count. No pulse is emitted.

## Timing
- Latency: if `sw_raw` changes and stays steady, edge 1 is the first edge that samples the new level into `s1`. `sw_stable`, the pulse and `event_mask` update on edge `DEBOUNCE_CYCLES+2`.
- Minimum accepted pulse width on `sw_raw`: `DEBOUNCE_CYCLES` cycles seen at `s2`. Anything shorter is rejected.
- `sw_rise`/`sw_fall` are high for exactly one `CLOCK50` cycle and are never both high on the same bit.
- `event_clear` takes effect on the edge it is sampled. `event_mask`/`event_pending` read 0 the following cycle unless a new change lands on that same edge.
- No combinational path from any input to any output.
- `sw_raw` is the only asynchronous crossing. It is confined to `s1`. Only `s1`→`s2` may be constrained as a synchroniser path.

## Structure
- Sub-module `debounce_bit`: one channel (synchroniser, counter, stable register, rise/fall pulse). Parameter `DEBOUNCE_CYCLES`. Instantiated WIDTH times via generate.
- Top of `switch_debounce`: generate loop plus event mask/pending/clear logic.
- Shared package/include: `CLK_HZ = 50_000_000` and `DEBOUNCE_MS = 10`. `DEBOUNCE_CYCLES` defaults to `CLK_HZ/1000*DEBOUNCE_MS`. No typedefs needed.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 8.
- Reset with `sw_raw`=4'b0000, hold 20 cycles → all outputs 0, no pulses.
- Step `sw_raw[0]` 0→1 and hold → `sw_stable`=4'b0001 and a single `sw_rise[0]` pulse on edge 10. `event_mask`=4'b0001, `event_pending`=1. Pulse width 1 cycle.
- Bounce `sw_raw[2]`: high 5 cycles, low 2 cycles, high 5 cycles, then low steady → no `sw_stable`, pulse or event change on bit 2.
- Release reset with `sw_raw`=4'b1010 steady → on edge 10, `sw_stable`=4'b1010, `sw_rise`=4'b1010 for 1 cycle, `event_mask`=4'b1010.
- With `event_mask`=4'b0001, strobe `event_clear` on the same edge that bit 3 stabilises high → `event_mask`=4'b1000, `event_pending`=1. A later lone clear gives `event_mask`=0, `event_pending`=0.
- Assert `RESET_N` low asynchronously at count 5 of a pending bit-1 change, release, then keep `sw_raw[1]` low → bit 1 stays 0, no `sw_fall` or `sw_rise` pulse, all outputs 0 while in reset.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Board timing constants shared by the switch debouncer and its channels.
package switch_debounce_pkg;

    localparam int unsigned CLK_HZ                  = 50_000_000;
    localparam int unsigned DEBOUNCE_MS             = 10;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch-side bundle: raw pins in, debounced levels, edge pulses and event flags out.
interface switch_debounce_if #(
    parameter int unsigned WIDTH = 4
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [WIDTH-1:0] event_mask;
    logic             event_pending;
    logic             event_clear;

    modport master (
        output sw_raw,
        output event_clear,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  event_mask,
        input  event_pending
    );

    modport slave (
        input  sw_raw,
        input  event_clear,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output event_mask,
        output event_pending
    );

endinterface

// File: rtl/debounce_bit.sv
// One switch channel: 2-FF synchroniser, persistence counter, stable level and edge pulses.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLOCK50,
    input  logic RESET_N,
    input  logic sw_raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // High on the edge where the new level has persisted long enough to be taken.
    assign accept = (s2 != stable) && (cnt == CNT_LAST);

    always_ff @(posedge CLOCK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            s1   <= sw_raw;
            s2   <= s1;
            rise <= accept & s2;
            fall <= accept & ~s2;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH slide switches and keeps a sticky, clearable change-event register.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              CLOCK50,
    input  logic              RESET_N,
    switch_debounce_if.slave  sw_if
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_next;
    logic             pending_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .CLOCK50 (CLOCK50),
            .RESET_N (RESET_N),
            .sw_raw  (sw_if.sw_raw[i]),
            .stable  (stable[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .accept  (accept[i])
        );
    end

    // A change landing on the same edge as a clear survives it.
    always_comb begin
        mask_next = (mask_q & ~{WIDTH{sw_if.event_clear}}) | accept;
    end

    always_ff @(posedge CLOCK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mask_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            mask_q    <= mask_next;
            pending_q <= |mask_next;
        end
    end

    assign sw_if.sw_stable     = stable;
    assign sw_if.sw_rise       = rise;
    assign sw_if.sw_fall       = fall;
    assign sw_if.event_mask    = mask_q;
    assign sw_if.event_pending = pending_q;

endmodule
